// File: rtl/demux8_stream.sv
// Eight-way stream demultiplexer with a small FIFO per output channel.
// Optional broadcast (in_bcast pushes to every channel) is enabled by defining DEMUX8_BCAST_EN.
module demux8_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
`ifdef DEMUX8_BCAST_EN
  input  logic               in_bcast,
`endif
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr [8];
  logic [PW-1:0]    rd_ptr [8];
  logic [CW-1:0]    count  [8];
  logic [WIDTH-1:0] mem    [8][DEPTH];

  logic [7:0] full;
  logic [7:0] push_en;
  logic [7:0] pop_en;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      full[i]      = (count[i] == FULL_CNT);
      out_valid[i] = (count[i] != '0);
      out_data[i*WIDTH +: WIDTH] = mem[i][rd_ptr[i]];
    end
  end

  // Readiness depends only on registered counts, never on out_ready.
  always_comb begin
    in_ready = ~full[in_sel];
    push_en  = '0;
`ifdef DEMUX8_BCAST_EN
    if (in_bcast) begin
      in_ready = ~(|full);
    end
    if (in_valid && in_ready) begin
      push_en = in_bcast ? 8'hFF : (8'b1 << in_sel);
    end
`else
    if (in_valid && in_ready) begin
      push_en = 8'b1 << in_sel;
    end
`endif
  end

  assign pop_en = out_valid & out_ready;

  for (genvar g = 0; g < 8; g++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr[g] <= '0;
        rd_ptr[g] <= '0;
        count[g]  <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem[g][e] <= '0;
        end
      end else begin
        if (push_en[g]) begin
          mem[g][wr_ptr[g]] <= in_data;
          wr_ptr[g]         <= wr_ptr[g] + PW'(1);
        end
        if (pop_en[g]) begin
          rd_ptr[g] <= rd_ptr[g] + PW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_en[g], pop_en[g]})
          2'b10:   count[g] <= count[g] + CW'(1);
          2'b01:   count[g] <= count[g] - CW'(1);
          default: count[g] <= count[g];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux8_stream.sv
// Directed bench for demux8_stream: table of per-cycle vectors plus reset and broadcast sequences.
module tb_demux8_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [2:0]  in_sel = '0;
`ifdef DEMUX8_BCAST_EN
  logic        in_bcast = 1'b0;
`endif
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [63:0] out_data;

  int checks = 0;
  int errors = 0;

  demux8_stream #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef DEMUX8_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] ordy;
    logic       ir;
    logic [7:0] ov;
    logic [2:0] ch;
    logic [7:0] hd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic [7:0] d,
                              input logic [7:0] ordy, input logic ir, input logic [7:0] ov,
                              input logic [2:0] ch, input logic [7:0] hd);
    vec_t t;
    t.v = v; t.sel = sel; t.d = d; t.ordy = ordy;
    t.ir = ir; t.ov = ov; t.ch = ch; t.hd = hd;
    return t;
  endfunction

  task automatic step(input vec_t t, input int idx);
    @(negedge clk);
    in_valid  = t.v;
    in_sel    = t.sel;
    in_data   = t.d;
    out_ready = t.ordy;
    #1;
    chk($sformatf("vec%0d in_ready", idx), 64'(in_ready), 64'(t.ir));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'(t.ov));
    if (t.ov[t.ch]) begin
      chk($sformatf("vec%0d head ch%0d", idx, t.ch), 64'(out_data[t.ch*8 +: 8]), 64'(t.hd));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = '0;
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] ov_acc;

    // Steering: one beat per channel, nothing consumed.
    ov_acc = '0;
    for (int k = 0; k < 8; k++) begin
      ov_acc[k] = 1'b1;
      vecs.push_back(mk(1'b1, 3'(k), 8'hA0 + 8'(k), 8'h00, 1'b1, ov_acc, 3'(k), 8'hA0 + 8'(k)));
    end
    vecs.push_back(mk(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd0, 8'h00));
    // Full ch3, isolated push to ch5, then drain ch3 in order.
    vecs.push_back(mk(1'b1, 3'd3, 8'h11, 8'h00, 1'b1, 8'h08, 3'd3, 8'h11));
    vecs.push_back(mk(1'b1, 3'd3, 8'h22, 8'h00, 1'b1, 8'h08, 3'd3, 8'h11));
    vecs.push_back(mk(1'b1, 3'd3, 8'h33, 8'h00, 1'b0, 8'h08, 3'd3, 8'h11));
    vecs.push_back(mk(1'b1, 3'd5, 8'h55, 8'h00, 1'b1, 8'h28, 3'd5, 8'h55));
    vecs.push_back(mk(1'b1, 3'd3, 8'h33, 8'h08, 1'b0, 8'h28, 3'd3, 8'h22));
    vecs.push_back(mk(1'b1, 3'd3, 8'h33, 8'h08, 1'b1, 8'h28, 3'd3, 8'h33));
    vecs.push_back(mk(1'b0, 3'd3, 8'h00, 8'h08, 1'b1, 8'h20, 3'd5, 8'h55));
    vecs.push_back(mk(1'b0, 3'd5, 8'h00, 8'h20, 1'b1, 8'h00, 3'd5, 8'h00));
    // Simultaneous push/pop on ch2 at count 1, then pointer wrap over 3*DEPTH beats.
    vecs.push_back(mk(1'b1, 3'd2, 8'h66, 8'h00, 1'b1, 8'h04, 3'd2, 8'h66));
    vecs.push_back(mk(1'b1, 3'd2, 8'h77, 8'h04, 1'b1, 8'h04, 3'd2, 8'h77));
    for (int j = 0; j < 6; j++) begin
      vecs.push_back(mk(1'b1, 3'd2, 8'h80 + 8'(j), 8'h04, 1'b1, 8'h04, 3'd2, 8'h80 + 8'(j)));
    end
    vecs.push_back(mk(1'b0, 3'd2, 8'h00, 8'h04, 1'b1, 8'h00, 3'd2, 8'h00));
    // out_ready on an empty channel is ignored.
    vecs.push_back(mk(1'b1, 3'd7, 8'hE7, 8'h7F, 1'b1, 8'h80, 3'd7, 8'hE7));
    vecs.push_back(mk(1'b0, 3'd7, 8'h00, 8'h80, 1'b1, 8'h00, 3'd7, 8'h00));

    // Reset state
    #1;
    chk("reset out_valid", 64'(out_valid), 64'h00);
    chk("reset in_ready", 64'(in_ready), 64'h1);
    chk("reset out_data", out_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i], i);

    // Reset mid-traffic: fill ch3, load ch1, then assert reset between edges.
    idle();
    in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h91;
    @(negedge clk);
    in_data = 8'h92;
    @(negedge clk);
    in_sel = 3'd1; in_data = 8'h93;
    @(negedge clk);
    in_valid = 1'b0; in_sel = 3'd3;
    #1;
    chk("pre-reset in_ready ch3 full", 64'(in_ready), 64'h0);
    chk("pre-reset out_valid", 64'(out_valid), 64'h0A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'h00);
    chk("async reset in_ready", 64'(in_ready), 64'h1);
    chk("async reset out_data", out_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset out_valid", 64'(out_valid), 64'h00);
    // First beat after reset lands in slot 0 of ch3.
    @(negedge clk);
    in_valid = 1'b1; in_sel = 3'd3; in_data = 8'hC3;
    @(posedge clk);
    #1;
    chk("post-reset push out_valid", 64'(out_valid), 64'h08);
    chk("post-reset push head", 64'(out_data[31:24]), 64'hC3);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 8'h08;
    @(negedge clk);
    out_ready = 8'h00;
    #1;
    chk("post-reset drain", 64'(out_valid), 64'h00);

`ifdef DEMUX8_BCAST_EN
    // Broadcast into all-empty channels.
    @(negedge clk);
    in_valid = 1'b1; in_bcast = 1'b1; in_sel = 3'd6; in_data = 8'h5A;
    #1;
    chk("bcast in_ready empty", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("bcast out_valid", 64'(out_valid), 64'hFF);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("bcast head ch%0d", c), 64'(out_data[c*8 +: 8]), 64'h5A);
    end
    // Fill ch0 with a targeted beat; a broadcast must then stall.
    @(negedge clk);
    in_bcast = 1'b0; in_sel = 3'd0; in_data = 8'h01;
    @(negedge clk);
    in_bcast = 1'b1; in_data = 8'h02;
    #1;
    chk("bcast in_ready one full", 64'(in_ready), 64'h0);
    in_valid = 1'b0; in_bcast = 1'b0;
    out_ready = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    out_ready = 8'h00;
    #1;
    chk("bcast drained", 64'(out_valid), 64'h00);
`endif

    prev = out_valid;
    chk("final idle out_valid", 64'(prev), 64'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
